dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port data RAM (CLK, MEMWrite, readMode, addr, inData, outData).
- Port 0 serves the CPU load/store stage. Port 1 serves a debug/DMA loader.
- Round-robin grant and one RAM access per grant.
- Read data and an alignment error flag are registered back to the served requester with a done pulse.

---
 rtl/dmem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port data RAM.
// Optional per-port completed-access counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [1:0]        mode0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic              err0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [1:0]        mode1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata1,
    output logic              MEMWrite,
    output logic [1:0]        readMode,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] inData,
    input  logic [DATA_W-1:0] outData,
    output logic [CNT_W-1:0]  gcnt0,
    output logic [CNT_W-1:0]  gcnt1
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_last;
    logic              r_we;
    logic              r_err;
    logic [1:0]        r_gnt;
    logic [1:0]        r_done;
    logic [1:0]        r_errout;
    logic [DATA_W-1:0] r_rdata [2];
    logic              r_memwrite;
    logic [1:0]        r_readmode;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_indata;

    logic [1:0]        w_req;
    logic              w_we    [2];
    logic [1:0]        w_mode  [2];
    logic [ADDR_W-1:0] w_addr  [2];
    logic [DATA_W-1:0] w_wdata [2];
    logic              w_launch;
    logic              w_port;
    logic              w_sel_err;

    assign w_req      = {req1, req0};
    assign w_we[0]    = we0;
    assign w_we[1]    = we1;
    assign w_mode[0]  = mode0;
    assign w_mode[1]  = mode1;
    assign w_addr[0]  = addr0;
    assign w_addr[1]  = addr1;
    assign w_wdata[0] = wdata0;
    assign w_wdata[1] = wdata1;

    function automatic logic addr_err(input logic [1:0] mode, input logic [ADDR_W-1:0] a);
        logic e;
        case (mode)
            2'b00:   e = (a[1:0] != 2'b00);
            2'b01:   e = a[0];
            2'b10:   e = 1'b0;
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    // In DONE only the port that was not just served may be picked up.
    always_comb begin
        w_launch = 1'b0;
        w_port   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_launch = |w_req;
                w_port   = (&w_req) ? ~r_last : w_req[1];
            end
            S_DONE: begin
                w_port   = ~r_owner;
                w_launch = w_req[~r_owner];
            end
            default: begin
                w_launch = 1'b0;
                w_port   = 1'b0;
            end
        endcase
    end

    assign w_sel_err = addr_err(w_mode[w_port], w_addr[w_port]);

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_gnt      <= 2'b00;
            r_done     <= 2'b00;
            r_errout   <= 2'b00;
            r_rdata[0] <= '0;
            r_rdata[1] <= '0;
            r_memwrite <= 1'b0;
            r_readmode <= 2'b00;
            r_addr     <= '0;
            r_indata   <= '0;
        end else begin
            r_gnt      <= 2'b00;
            r_done     <= 2'b00;
            r_errout   <= 2'b00;
            r_memwrite <= 1'b0;
            r_readmode <= 2'b00;
            r_addr     <= '0;
            r_indata   <= '0;
            case (r_state)
                S_ACCESS: begin
                    r_done[r_owner]   <= 1'b1;
                    r_errout[r_owner] <= r_err;
                    if (!r_we && !r_err) begin
                        r_rdata[r_owner] <= outData;
                    end
                    r_last  <= r_owner;
                    r_state <= S_DONE;
                end
                default: begin
                    if (w_launch) begin
                        r_owner       <= w_port;
                        r_we          <= w_we[w_port];
                        r_err         <= w_sel_err;
                        r_gnt[w_port] <= 1'b1;
                        r_memwrite    <= w_we[w_port] & ~w_sel_err;
                        r_readmode    <= w_mode[w_port];
                        r_addr        <= w_addr[w_port];
                        r_indata      <= w_wdata[w_port];
                        r_state       <= S_ACCESS;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Gating with reset keeps a write from landing at an edge that abandons the access.
    assign MEMWrite = r_memwrite & reset;
    assign readMode = r_readmode;
    assign addr     = r_addr;
    assign inData   = r_indata;
    assign gnt0     = r_gnt[0];
    assign gnt1     = r_gnt[1];
    assign done0    = r_done[0];
    assign done1    = r_done[1];
    assign err0     = r_errout[0];
    assign err1     = r_errout[1];
    assign rdata0   = r_rdata[0];
    assign rdata1   = r_rdata[1];

`ifdef DMEM_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] r_gcnt;
        always_ff @(posedge CLK) begin
            if (!reset) begin
                r_gcnt <= '0;
            end else if (r_state == S_DONE && r_owner == 1'(gi) && !r_err && r_gcnt != '1) begin
                r_gcnt <= r_gcnt + CNT_ONE;
            end
        end
    end

    assign gcnt0 = g_cnt[0].r_gcnt;
    assign gcnt1 = g_cnt[1].r_gcnt;
`else
    assign gcnt0 = '0;
    assign gcnt1 = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-addressed little-endian RAM, directed scenarios and
// randomized two-port traffic checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        t_reset;
    logic        t_req   [2];
    logic        t_we    [2];
    logic [1:0]  t_mode  [2];
    logic [7:0]  t_addr  [2];
    logic [31:0] t_wdata [2];

    logic        reset, req0, we0, req1, we1;
    logic [1:0]  mode0, mode1;
    logic [7:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, done0, err0, gnt1, done1, err1;
    logic [31:0] rdata0, rdata1;
    logic        MEMWrite;
    logic [1:0]  readMode;
    logic [7:0]  addr;
    logic [31:0] inData, outData;
    logic [15:0] gcnt0, gcnt1;

    assign reset  = t_reset;
    assign req0   = t_req[0];   assign req1   = t_req[1];
    assign we0    = t_we[0];    assign we1    = t_we[1];
    assign mode0  = t_mode[0];  assign mode1  = t_mode[1];
    assign addr0  = t_addr[0];  assign addr1  = t_addr[1];
    assign wdata0 = t_wdata[0]; assign wdata1 = t_wdata[1];

    logic [1:0] d_gnt, d_done, d_err;
    assign d_gnt  = {gnt1, gnt0};
    assign d_done = {done1, done0};
    assign d_err  = {err1, err0};

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .CNT_W(16)) dut (
        .CLK(CLK), .reset(reset),
        .req0(req0), .we0(we0), .mode0(mode0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .mode1(mode1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .err1(err1), .rdata1(rdata1),
        .MEMWrite(MEMWrite), .readMode(readMode), .addr(addr), .inData(inData),
        .outData(outData), .gcnt0(gcnt0), .gcnt1(gcnt1)
    );

    // RAM seen by the DUT: combinational read, write on posedge.
    logic [7:0] ram [256] = '{default: 8'h00};
    always_comb begin
        case (readMode)
            2'b00:   outData = {ram[8'(addr + 8'd3)], ram[8'(addr + 8'd2)], ram[8'(addr + 8'd1)], ram[addr]};
            2'b01:   outData = {16'h0000, ram[8'(addr + 8'd1)], ram[addr]};
            2'b10:   outData = {24'h000000, ram[addr]};
            default: outData = 32'h0;
        endcase
    end
    always @(posedge CLK) begin
        if (MEMWrite) begin
            ram[addr] <= inData[7:0];
            if (readMode != 2'b10) ram[8'(addr + 8'd1)] <= inData[15:8];
            if (readMode == 2'b00) begin
                ram[8'(addr + 8'd2)] <= inData[23:16];
                ram[8'(addr + 8'd3)] <= inData[31:24];
            end
        end
    end

    // Reference model: a grant made at edge g owns the RAM until g+1, reports done until g+2.
    logic [7:0]  ref_mem [256] = '{default: 8'h00};
    int          edge_no = 0;
    int          g_edge  = -10;
    bit          m_owner, m_last, m_we, m_err;
    logic [1:0]  m_mode;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata [2];
    logic [15:0] m_cnt   [2];
    int          n_chk = 0;
    int          n_err = 0;

    function automatic bit bad_align(input logic [1:0] mode, input logic [7:0] a);
        if (mode == 2'd3) return 1'b1;
        if (mode == 2'd0) return (int'(a) % 4) != 0;
        if (mode == 2'd1) return (int'(a) % 2) != 0;
        return 1'b0;
    endfunction

    function automatic int nbytes(input logic [1:0] mode);
        return (mode == 2'd0) ? 4 : (mode == 2'd1) ? 2 : 1;
    endfunction

    task automatic ref_write(input logic [1:0] mode, input logic [7:0] a, input logic [31:0] d);
        for (int i = 0; i < nbytes(mode); i++) ref_mem[8'(int'(a) + i)] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_read(input logic [1:0] mode, input logic [7:0] a);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nbytes(mode); i++) v[8*i +: 8] = ref_mem[8'(int'(a) + i)];
        return v;
    endfunction

    task automatic model_edge();
        int p;
        bit found;
        edge_no++;
        if (!t_reset) begin
            g_edge = -10; m_last = 1'b1; m_owner = 1'b0; m_err = 1'b0;
            m_rdata[0] = 32'h0; m_rdata[1] = 32'h0; m_cnt[0] = 16'h0; m_cnt[1] = 16'h0;
            return;
        end
        if (edge_no == g_edge + 1) begin
            if (!m_err) begin
                if (m_we) ref_write(m_mode, m_addr, m_wdata);
                else      m_rdata[m_owner] = ref_read(m_mode, m_addr);
            end
            m_last = m_owner;
            return;
        end
        found = 1'b0;
        p = 0;
        if (edge_no == g_edge + 2) begin
`ifdef DMEM_ARB_STATS_EN
            if (!m_err && m_cnt[m_owner] != 16'hffff) m_cnt[m_owner] = m_cnt[m_owner] + 16'd1;
`endif
            p = m_owner ? 0 : 1;
            found = t_req[p];
        end else if (t_req[0] && t_req[1]) begin
            p = m_last ? 0 : 1; found = 1'b1;
        end else if (t_req[0]) begin
            p = 0; found = 1'b1;
        end else if (t_req[1]) begin
            p = 1; found = 1'b1;
        end
        if (found) begin
            g_edge = edge_no; m_owner = (p == 1);
            m_we = t_we[p]; m_mode = t_mode[p]; m_addr = t_addr[p]; m_wdata = t_wdata[p];
            m_err = bad_align(m_mode, m_addr);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30) $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic check_all();
        bit acc, dn;
        acc = (edge_no == g_edge);
        dn  = (edge_no == g_edge + 1);
        chk("gnt0",     32'(gnt0),  32'(acc && !m_owner));
        chk("gnt1",     32'(gnt1),  32'(acc && m_owner));
        chk("done0",    32'(done0), 32'(dn && !m_owner));
        chk("done1",    32'(done1), 32'(dn && m_owner));
        chk("err0",     32'(err0),  32'(dn && !m_owner && m_err));
        chk("err1",     32'(err1),  32'(dn && m_owner && m_err));
        chk("MEMWrite", 32'(MEMWrite), 32'(acc && m_we && !m_err && t_reset));
        chk("readMode", 32'(readMode), 32'(acc ? m_mode : 2'b00));
        chk("addr",     32'(addr),     32'(acc ? m_addr : 8'h00));
        chk("inData",   inData,        acc ? m_wdata : 32'h0);
        chk("rdata0",   rdata0, m_rdata[0]);
        chk("rdata1",   rdata1, m_rdata[1]);
        chk("gcnt0",    32'(gcnt0), 32'(m_cnt[0]));
        chk("gcnt1",    32'(gcnt1), 32'(m_cnt[1]));
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
    endtask

    task automatic do_access(input int p, input bit we, input logic [1:0] mode, input logic [7:0] a,
                             input logic [31:0] d, output int gnt_at, output int done_at,
                             output bit got_err, output logic [31:0] got_rdata, output bit saw_wr);
        t_req[p] = 1'b1; t_we[p] = we; t_mode[p] = mode; t_addr[p] = a; t_wdata[p] = d;
        gnt_at = -1; done_at = -1; got_err = 1'b0; got_rdata = 32'h0; saw_wr = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (MEMWrite) saw_wr = 1'b1;
            if (d_gnt[p] && gnt_at < 0) gnt_at = k;
            if (d_done[p]) begin
                done_at = k; got_err = d_err[p]; got_rdata = p ? rdata1 : rdata0;
                break;
            end
        end
        t_req[p] = 1'b0;
        chk("access_timeout", 32'(done_at > 0), 32'd1);
        $display("txn port%0d we=%0d mode=%0d addr=%h wdata=%h err=%0d rdata=%h gnt@%0d done@%0d",
                 p, we, mode, a, d, got_err, got_rdata, gnt_at, done_at);
        step();
    endtask

    task automatic pulse_reset(input int cycles);
        t_reset = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        t_reset = 1'b1;
    endtask

    int          ga, da;
    bit          ge, sw;
    logic [31:0] rd;
    int          gport [6];
    int          gcyc  [6];
    int          exp_order [6] = '{0, 1, 0, 1, 0, 1};
    int          ng, ndone;
    bit          inflight [2];

    initial begin
        t_reset = 1'b0;
        for (int p = 0; p < 2; p++) begin
            t_req[p] = 1'b0; t_we[p] = 1'b0; t_mode[p] = 2'b00; t_addr[p] = 8'h00; t_wdata[p] = 32'h0;
        end

        // Reset for 4 cycles, then idle.
        @(negedge CLK);
        pulse_reset(4);
        step();
        chk("post_reset_memwrite", 32'(MEMWrite), 32'd0);
        chk("post_reset_rdata0", rdata0, 32'h0);

        // Word write then read on port 0 with latency check.
        do_access(0, 1'b1, 2'b00, 8'h00, 32'hbbbba00a, ga, da, ge, rd, sw);
        chk("wr_gnt_latency", 32'(ga), 32'd1);
        chk("wr_done_latency", 32'(da), 32'd2);
        chk("wr_err", 32'(ge), 32'd0);
        do_access(0, 1'b0, 2'b00, 8'h00, 32'h0, ga, da, ge, rd, sw);
        chk("rd_word0", rd, 32'hbbbba00a);
        chk("rd_err", 32'(ge), 32'd0);

        // Halfword and byte writes via port 1, word reads via port 0.
        do_access(1, 1'b1, 2'b01, 8'h02, 32'hbbbba00a, ga, da, ge, rd, sw);
        do_access(1, 1'b1, 2'b10, 8'h04, 32'hbbbba00a, ga, da, ge, rd, sw);
        do_access(0, 1'b0, 2'b00, 8'h00, 32'h0, ga, da, ge, rd, sw);
        chk("rd_merge_half", rd, 32'ha00aa00a);
        do_access(0, 1'b0, 2'b00, 8'h04, 32'h0, ga, da, ge, rd, sw);
        chk("rd_merge_byte", rd, 32'h0000000a);

        // Continuous contention after a reset: port 0 first, strict alternation.
        pulse_reset(2);
        t_req[0] = 1'b1; t_we[0] = 1'b0; t_mode[0] = 2'b00; t_addr[0] = 8'h00;
        t_req[1] = 1'b1; t_we[1] = 1'b0; t_mode[1] = 2'b00; t_addr[1] = 8'h04;
        ng = 0; ndone = 0;
        for (int k = 0; k < 40 && ndone < 6; k++) begin
            step();
            if (d_gnt != 2'b00 && ng < 6) begin
                gport[ng] = d_gnt[1] ? 1 : 0; gcyc[ng] = k; ng++;
                if (ng == 6) begin t_req[0] = 1'b0; t_req[1] = 1'b0; end
            end
            if (d_done != 2'b00) begin
                ndone++;
                $display("txn contention done port%0d rdata=%h", d_done[1] ? 1 : 0, d_done[1] ? rdata1 : rdata0);
            end
        end
        step();
        chk("contention_dones", 32'(ndone), 32'd6);
        for (int i = 0; i < ng; i++) chk("contention_order", 32'(gport[i]), 32'(exp_order[i]));
        for (int i = 1; i < ng; i++) chk("contention_gap", 32'(gcyc[i] - gcyc[i-1]), 32'd2);

        // Alignment errors leave RAM and rdata0 untouched.
        do_access(0, 1'b0, 2'b00, 8'h00, 32'h0, ga, da, ge, rd, sw);
        chk("pre_err_rd", rd, 32'ha00aa00a);
        do_access(0, 1'b1, 2'b00, 8'h01, 32'h12345678, ga, da, ge, rd, sw);
        chk("err_word", 32'(ge), 32'd1); chk("err_word_nowr", 32'(sw), 32'd0); chk("err_word_rdata", rd, 32'ha00aa00a);
        do_access(0, 1'b1, 2'b01, 8'h03, 32'h12345678, ga, da, ge, rd, sw);
        chk("err_half", 32'(ge), 32'd1); chk("err_half_nowr", 32'(sw), 32'd0);
        do_access(0, 1'b0, 2'b01, 8'h03, 32'h0, ga, da, ge, rd, sw);
        chk("err_half_rd", 32'(ge), 32'd1); chk("err_half_rd_rdata", rd, 32'ha00aa00a);
        do_access(0, 1'b1, 2'b11, 8'h00, 32'h12345678, ga, da, ge, rd, sw);
        chk("err_mode3", 32'(ge), 32'd1); chk("err_mode3_nowr", 32'(sw), 32'd0);
        do_access(0, 1'b0, 2'b10, 8'h03, 32'h0, ga, da, ge, rd, sw);
        chk("byte_rd_ok", 32'(ge), 32'd0); chk("byte_rd_val", rd, 32'h000000a0);
        do_access(0, 1'b0, 2'b00, 8'h00, 32'h0, ga, da, ge, rd, sw);
        chk("ram_unchanged", rd, 32'ha00aa00a);

        // Reset during the ACCESS of a write.
        do_access(0, 1'b1, 2'b00, 8'h10, 32'h11111111, ga, da, ge, rd, sw);
        t_req[0] = 1'b1; t_we[0] = 1'b1; t_mode[0] = 2'b00; t_addr[0] = 8'h10; t_wdata[0] = 32'h22222222;
        step();
        chk("abort_gnt", 32'(gnt0), 32'd1);
        t_reset = 1'b0;
        step();
        chk("abort_no_done", 32'(done0), 32'd0);
        t_req[0] = 1'b0;
        step();
        t_reset = 1'b1;
        step();
        chk("abort_no_done2", 32'(done0), 32'd0);
        do_access(0, 1'b0, 2'b00, 8'h10, 32'h0, ga, da, ge, rd, sw);
        chk("abort_ram", rd, 32'h11111111);

        // Grant counter: 3 good + 1 error on port 0.
        pulse_reset(1);
        for (int i = 0; i < 3; i++) do_access(0, 1'b0, 2'b10, 8'(i), 32'h0, ga, da, ge, rd, sw);
        do_access(0, 1'b0, 2'b00, 8'h02, 32'h0, ga, da, ge, rd, sw);
`ifdef DMEM_ARB_STATS_EN
        chk("gcnt0_literal", 32'(gcnt0), 32'd3);
`else
        chk("gcnt0_literal", 32'(gcnt0), 32'd0);
`endif

        // Randomized two-port traffic with occasional resets.
        inflight[0] = 1'b0; inflight[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                if (d_gnt[p]) inflight[p] = 1'b1;
                if (d_done[p]) begin
                    $display("txn rand port%0d we=%0d mode=%0d addr=%h err=%0d rdata=%h",
                             p, t_we[p], t_mode[p], t_addr[p], d_err[p], p ? rdata1 : rdata0);
                    t_req[p] = 1'b0; inflight[p] = 1'b0;
                end else if (!t_req[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        t_req[p] = 1'b1; t_we[p] = 1'($urandom_range(0, 1));
                        t_mode[p] = 2'($urandom_range(0, 3)); t_addr[p] = 8'($urandom_range(0, 31));
                        t_wdata[p] = $urandom;
                    end
                end else if (!inflight[p] && $urandom_range(0, 15) == 0) begin
                    t_req[p] = 1'b0;
                end
            end
            t_reset = ($urandom_range(0, 399) != 0);
            if (!t_reset) begin
                t_req[0] = 1'b0; t_req[1] = 1'b0; inflight[0] = 1'b0; inflight[1] = 1'b0;
            end
        end
        t_reset = 1'b1; t_req[0] = 1'b0; t_req[1] = 1'b0;
        for (int i = 0; i < 4; i++) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
